// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT stages.
// Rows arrive as even/odd column pairs; columns leave as even/odd row pairs.
module dct_transpose_buffer #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_c0,
  input  logic [DATA_WIDTH-1:0] i_c1,
  input  logic                  i_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_p0,
  output logic [DATA_WIDTH-1:0] o_p1,
  output logic                  o_vld,
  output logic                  o_sync,
  output logic                  o_last,
  output logic                  o_ovf
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_t;
  typedef enum logic {IDLE, READ} rd_state_t;

  logic [DATA_WIDTH-1:0] mem [0:127];
  bank_t [1:0] bank_st, bank_nxt;

  logic [4:0] wr_cnt;
  logic       wr_bank, drop;
  logic [4:0] rd_cnt, m_nxt;
  logic       rd_bank, rb_nxt;
  rd_state_t  state, state_nxt;

  logic       hs, fin, launch, cand, load;
  logic       wr_acc, wr_done;
  logic [1:0] freed, writable, full_next;
  logic [6:0] wa0, wa1, ra0, ra1;

  assign hs  = o_vld & i_rdy;
  assign fin = hs & (rd_cnt == 5'd31);

  // A bank released by this cycle's final read counts as writable and
  // a bank completed by this cycle's last write counts as readable.
  always_comb begin
    freed          = '0;
    freed[rd_bank] = fin;
    for (int b = 0; b < 2; b++) begin
      writable[b]  = (bank_st[b] == EMPTY) | freed[b];
      full_next[b] = (bank_st[b] == FULL) | (wr_done & (wr_bank == 1'(b)));
    end
  end

  assign wr_acc  = i_vld & ((wr_cnt == 5'd0) ? writable[wr_bank] : ~drop);
  assign wr_done = wr_acc & (wr_cnt == 5'd31);

  // beat n -> row n/4, cols 2*(n%4) and 2*(n%4)+1
  assign wa0 = {wr_bank, wr_cnt[4:2], wr_cnt[1:0], 1'b0};
  assign wa1 = {wr_bank, wr_cnt[4:2], wr_cnt[1:0], 1'b1};

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wa0] <= i_c0;
      mem[wa1] <= i_c1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      drop    <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (i_vld) begin
      wr_cnt <= wr_cnt + 5'd1;
      if (wr_cnt == 5'd31)
        wr_bank <= ~wr_bank;
      if (wr_cnt == 5'd0) begin
        drop <= ~writable[wr_bank];
        if (!writable[wr_bank])
          o_ovf <= 1'b1;
      end
    end
  end

  // Read sequencer: the only full bank is the oldest, since one write port
  // can complete at most one bank per cycle and a full bank launches at once.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    cand      = 1'b0;
    case (state)
      IDLE: begin
        if (|full_next) begin
          launch = 1'b1;
          cand   = ~full_next[0];
        end
      end
      READ: begin
        if (fin) begin
          cand   = ~rd_bank;
          launch = full_next[cand];
          if (!launch)
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (launch)
      state_nxt = READ;
  end

  assign load   = launch | (hs & ~fin);
  assign m_nxt  = launch ? 5'd0 : rd_cnt + 5'd1;
  assign rb_nxt = launch ? cand : rd_bank;

  // beat m -> col m/4, rows 2*(m%4) and 2*(m%4)+1
  assign ra0 = {rb_nxt, m_nxt[1:0], 1'b0, m_nxt[4:2]};
  assign ra1 = {rb_nxt, m_nxt[1:0], 1'b1, m_nxt[4:2]};

  always_comb begin
    bank_nxt = bank_st;
    for (int b = 0; b < 2; b++) begin
      if (freed[b])
        bank_nxt[b] = EMPTY;
      if (wr_acc && wr_bank == 1'(b)) begin
        if (wr_cnt == 5'd0)
          bank_nxt[b] = FILLING;
        if (wr_cnt == 5'd31)
          bank_nxt[b] = FULL;
      end
      if (launch && cand == 1'(b))
        bank_nxt[b] = READING;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bank_st <= {EMPTY, EMPTY};
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      o_p0    <= '0;
      o_p1    <= '0;
      o_vld   <= 1'b0;
      o_sync  <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      bank_st <= bank_nxt;
      state   <= state_nxt;
      if (load) begin
        rd_bank <= rb_nxt;
        rd_cnt  <= m_nxt;
        o_p0    <= mem[ra0];
        o_p1    <= mem[ra1];
        o_vld   <= 1'b1;
        o_sync  <= (m_nxt[1:0] == 2'd0);
        o_last  <= (m_nxt == 5'd31);
      end else if (fin) begin
        rd_cnt <= '0;
        o_vld  <= 1'b0;
        o_sync <= 1'b0;
        o_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed bench for dct_transpose_buffer: single, back-to-back, backpressure,
// input gaps, overflow and mid-block reset.
module tb_dct_transpose_buffer;
  localparam int DW = 12;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_vld = 1'b0;
  logic          i_rdy = 1'b1;
  logic [DW-1:0] i_c0 = '0;
  logic [DW-1:0] i_c1 = '0;
  logic [DW-1:0] o_p0, o_p1;
  logic          o_vld, o_sync, o_last, o_ovf;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int rd_idx = 0;
  int mcnt = 0;
  int vld_total = 0;
  int rdy_mode = 0;
  int pat = 0;
  int v0;
  logic          have_prev = 1'b0;
  logic [DW-1:0] prev_p0, prev_p1;
  logic          prev_sync, prev_last;

  always #5 i_clk = ~i_clk;

  dct_transpose_buffer #(.DATA_WIDTH(DW)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_c0   (i_c0),
    .i_c1   (i_c1),
    .i_vld  (i_vld),
    .i_rdy  (i_rdy),
    .o_p0   (o_p0),
    .o_p1   (o_p1),
    .o_vld  (o_vld),
    .o_sync (o_sync),
    .o_last (o_last),
    .o_ovf  (o_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"},  32'(o_vld),  0);
    chk({tag, "_p0"},   32'(o_p0),   0);
    chk({tag, "_p1"},   32'(o_p1),   0);
    chk({tag, "_sync"}, 32'(o_sync), 0);
    chk({tag, "_last"}, 32'(o_last), 0);
    chk({tag, "_ovf"},  32'(o_ovf),  0);
  endtask

  task automatic update_rdy();
    case (rdy_mode)
      0: i_rdy = 1'b1;
      1: i_rdy = 1'b0;
      default: begin
        i_rdy = (pat == 0) || (pat == 3);
        pat   = (pat + 1) % 4;
      end
    endcase
  endtask

  // Observe outputs mid-cycle; a handshake is o_vld && i_rdy at this point.
  task automatic monitor();
    int e;
    if (i_reset) begin
      rd_idx    = exp_q.size();
      mcnt      = 0;
      have_prev = 1'b0;
      return;
    end
    if (o_vld) vld_total++;
    if (have_prev) begin
      chk("hold_vld",  32'(o_vld),  1);
      chk("hold_p0",   32'(o_p0),   32'(prev_p0));
      chk("hold_p1",   32'(o_p1),   32'(prev_p1));
      chk("hold_sync", 32'(o_sync), 32'(prev_sync));
      chk("hold_last", 32'(o_last), 32'(prev_last));
    end
    if (!o_vld) chk("idle_flags", 32'({o_sync, o_last}), 0);
    if (o_vld && i_rdy) begin
      if (rd_idx >= exp_q.size()) begin
        chk("extra_out", 32'(o_vld), 0);
      end else begin
        e = exp_q[rd_idx] + 16 * (mcnt % 4) + mcnt / 4;
        chk("out_p0",   32'(o_p0),   32'(e));
        chk("out_p1",   32'(o_p1),   32'(e + 8));
        chk("out_sync", 32'(o_sync), 32'(mcnt % 4 == 0));
        chk("out_last", 32'(o_last), 32'(mcnt == 31));
        mcnt++;
        if (mcnt == 32) begin
          mcnt = 0;
          rd_idx++;
        end
      end
    end
    have_prev = o_vld && !i_rdy;
    prev_p0   = o_p0;
    prev_p1   = o_p1;
    prev_sync = o_sync;
    prev_last = o_last;
  endtask

  // One clock: monitor at negedge, inputs change 1ns after posedge.
  task automatic step();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    update_rdy();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_beat(input int base, input int k);
    i_vld = 1'b1;
    i_c0  = DW'(base + 2 * k);
    i_c1  = DW'(base + 2 * k + 1);
    step();
    i_vld = 1'b0;
  endtask

  task automatic send_block(input int base, input int gap);
    for (int k = 0; k < 32; k++) begin
      send_beat(base, k);
      if (k < 31) idle(gap);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && rd_idx < exp_q.size(); i++) step();
    chk(tag, 32'(rd_idx), 32'(exp_q.size()));
  endtask

  task automatic set_mode(input int m);
    rdy_mode = m;
    pat      = 0;
    update_rdy();
  endtask

  initial begin
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    chk_zero("rst");

    // single block, values 0..63
    exp_q.push_back(0);
    send_block(0, 0);
    chk("lat_single", 32'(o_vld), 1);
    drain("drain_single");
    idle(3);

    // two blocks back to back: 64 contiguous output beats
    exp_q.push_back(64);
    send_block(64, 0);
    v0 = vld_total;
    exp_q.push_back(128);
    send_block(128, 0);
    idle(32);
    chk("b2b_contig", 32'(vld_total - v0), 64);
    drain("drain_b2b");
    idle(2);
    chk("b2b_end_vld", 32'(o_vld), 0);
    chk("b2b_ovf", 32'(o_ovf), 0);

    // backpressure 1,0,0,1
    set_mode(2);
    exp_q.push_back(192);
    send_block(192, 0);
    chk("lat_bp", 32'(o_vld), 1);
    drain("drain_bp");
    set_mode(0);
    idle(3);

    // valid every third cycle
    exp_q.push_back(256);
    send_block(256, 2);
    chk("lat_gap", 32'(o_vld), 1);
    drain("drain_gap");
    idle(3);

    // overflow: third block dropped while both banks are occupied
    set_mode(1);
    exp_q.push_back(320);
    send_block(320, 0);
    exp_q.push_back(384);
    send_block(384, 0);
    chk("ovf_pre", 32'(o_ovf), 0);
    send_beat(448, 0);
    chk("ovf_beat0", 32'(o_ovf), 1);
    for (int k = 1; k < 32; k++) send_beat(448, k);
    set_mode(0);
    drain("drain_ovf");
    idle(4);
    chk("ovf_sticky", 32'(o_ovf), 1);
    chk("ovf_end_vld", 32'(o_vld), 0);

    // reset at write beat 17 of a block while the previous one is streaming
    exp_q.push_back(512);
    send_block(512, 0);
    for (int k = 0; k < 17; k++) send_beat(576, k);
    i_reset = 1'b1;
    i_vld   = 1'b1;
    i_c0    = DW'(576 + 34);
    i_c1    = DW'(576 + 35);
    step();
    i_reset = 1'b0;
    i_vld   = 1'b0;
    chk_zero("rst_mid");
    idle(2);
    exp_q.push_back(640);
    send_block(640, 0);
    chk("lat_fresh", 32'(o_vld), 1);
    drain("drain_fresh");
    idle(4);
    chk("fresh_end_vld", 32'(o_vld), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dct_transpose_buffer.md
DCT_TRANSPOSE_BUFFER -- requirements
Module: dct_transpose_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, giving the coefficient width of every data port.
REQ-002 The block SHALL use a fixed 8x8 block size (32 input pairs per block); this is not parameterised.
REQ-003 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_c0  input  DATA_WIDTH  row-DCT coefficient, even column of the current pair.
REQ-006 i_c1  input  DATA_WIDTH  row-DCT coefficient, odd column of the current pair.
REQ-007 i_vld  input  1  i_c0/i_c1 valid this cycle; no input backpressure exists.
REQ-008 i_rdy  input  1  downstream (column DCT stage) accepts the output pair this cycle.
REQ-009 o_p0  output  DATA_WIDTH  transposed element, even row of the current column pair.
REQ-010 o_p1  output  DATA_WIDTH  transposed element, odd row of the current column pair.
REQ-011 o_vld  output  1  o_p0/o_p1 valid.
REQ-012 o_sync  output  1  high with o_vld on the first pair of each column.
REQ-013 o_last  output  1  high with o_vld on the final pair (32nd) of a block.
REQ-014 o_ovf  output  1  sticky overflow flag.

Function
REQ-015 Storage SHALL be two banks (ping-pong) of 64 x DATA_WIDTH; each bank state SHALL be EMPTY, FILLING, FULL or READING.
REQ-016 Write counter wr_cnt (0..31) SHALL advance by one on each accepted i_vld beat and wrap 31->0, toggling the write bank on wrap.
REQ-017 Write beat n SHALL store i_c0 at (row n/4, col 2*(n%4)) and i_c1 at (row n/4, col 2*(n%4)+1).
REQ-018 A beat with wr_cnt=0 SHALL be accepted only if the target bank is EMPTY; otherwise the whole block (32 beats) SHALL be dropped, wr_cnt still advancing, and o_ovf set to 1 until reset.
REQ-019 On accepting beat 31 the bank SHALL go FULL; gaps in i_vld SHALL NOT reset wr_cnt.
REQ-020 Read side states: IDLE, READ. IDLE->READ when any bank is FULL (oldest first); that bank goes READING.
REQ-021 Read beat m (0..31) SHALL present o_p0=(row 2*(m%4), col m/4) and o_p1=(row 2*(m%4)+1, col m/4) from registered outputs.
REQ-022 The first read beat SHALL appear with o_vld=1 exactly one cycle after the cycle accepting write beat 31 (latency 1 from last input).
REQ-023 The read counter SHALL advance only on o_vld && i_rdy; while i_rdy=0, o_p0/o_p1/o_sync/o_last SHALL hold stable.
REQ-024 o_sync SHALL be 1 iff o_vld and m%4==0; o_last SHALL be 1 iff o_vld and m==31.
REQ-025 On handshake of m=31 the bank SHALL become EMPTY in that same cycle; if the other bank is FULL, its m=0 SHALL appear the next cycle with no bubble, else o_vld SHALL drop to 0.
REQ-026 A write beat 0 into a bank in the same cycle as that bank's final read handshake SHALL be accepted (freed bank is writable that cycle).
REQ-027 Simultaneous write and read on different banks SHALL proceed independently every cycle.
REQ-028 Sustained throughput SHALL be one pair per cycle on both sides when i_rdy=1.

Reset
REQ-029 With i_reset=1 at a clock edge: wr_cnt=0, read counter=0, both banks EMPTY, write bank=0, read state IDLE.
REQ-030 Reset values: o_vld=0, o_sync=0, o_last=0, o_ovf=0, o_p0=0, o_p1=0; bank contents need not be cleared.
REQ-031 Reset mid-block SHALL discard all partial and full blocks; first i_vld after reset is write beat 0 of bank 0.

Verification
REQ-032 Single block: i_c0=2k, i_c1=2k+1 on beat k (values 0..63 row-major), i_rdy=1 -> o_vld one cycle after beat 31; outputs pairs (0,8),(16,24),(32,40),(48,56),(1,9),...,(55,63); o_sync on pairs 0,4,...,28; o_last on pair 31.
REQ-033 Back-to-back: two blocks continuously, i_rdy=1 -> 64 output beats contiguous, second block transposed correctly, o_ovf=0.
REQ-034 Backpressure: i_rdy toggled 1,0,0,1 repeatedly -> outputs held stable while i_rdy=0, sequence as REQ-032, no loss.
REQ-035 Overflow: i_rdy=0 throughout, three blocks written -> third block dropped, o_ovf=1 from its beat 0; after i_rdy=1, only blocks 1 and 2 emerge.
REQ-036 Reset mid-block: i_reset at write beat 17 of block 1 -> all outputs 0 next cycle; fresh block after reset emerges alone and correct.
REQ-037 Input gaps: i_vld=1 every third cycle for one block -> same output as REQ-032, o_vld one cycle after the 32nd valid beat.
